// File: rtl/mem_stage.sv
// MEM stage of the RV32I core: issues loads/stores to the memory controller,
// extends load data, and stalls the pipeline while an access is outstanding.

`ifndef AluOpBus
`define AluOpBus 4:0
`endif

module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        in_w_addr,
    input  logic              in_w_req,
    input  logic [DATA_W-1:0] in_w_data,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [`AluOpBus]  in_aluop,
    output logic              mctl_req,
    output logic              mctl_we,
    output logic [ADDR_W-1:0] mctl_addr,
    output logic [DATA_W-1:0] mctl_wdata,
    output logic [1:0]        mctl_len,
    input  logic              mctl_done,
    input  logic [DATA_W-1:0] mctl_rdata,
    output logic [4:0]        wb_w_addr,
    output logic              wb_w_req,
    output logic [DATA_W-1:0] wb_w_data,
    output logic              stall_req
);

    localparam logic [4:0] EX_LB  = 5'h10;
    localparam logic [4:0] EX_LH  = 5'h11;
    localparam logic [4:0] EX_LW  = 5'h12;
    localparam logic [4:0] EX_LBU = 5'h13;
    localparam logic [4:0] EX_LHU = 5'h14;
    localparam logic [4:0] EX_SB  = 5'h15;
    localparam logic [4:0] EX_SH  = 5'h16;
    localparam logic [4:0] EX_SW  = 5'h17;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_next;
    logic              is_load, is_store, is_mem, done_now;
    logic [1:0]        op_len;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        op_len   = 2'd3;
        case (in_aluop)
            EX_LB, EX_LBU: begin is_load = 1'b1;  op_len = 2'd0; end
            EX_LH, EX_LHU: begin is_load = 1'b1;  op_len = 2'd1; end
            EX_LW:         begin is_load = 1'b1;  op_len = 2'd3; end
            EX_SB:         begin is_store = 1'b1; op_len = 2'd0; end
            EX_SH:         begin is_store = 1'b1; op_len = 2'd1; end
            EX_SW:         begin is_store = 1'b1; op_len = 2'd3; end
            default:       ;
        endcase
        is_mem = is_load | is_store;
    end

    always_comb begin
        load_data = mctl_rdata;
        case (in_aluop)
            EX_LB:   load_data = {{(DATA_W-8){mctl_rdata[7]}}, mctl_rdata[7:0]};
            EX_LH:   load_data = {{(DATA_W-16){mctl_rdata[15]}}, mctl_rdata[15:0]};
            EX_LBU:  load_data = {{(DATA_W-8){1'b0}}, mctl_rdata[7:0]};
            EX_LHU:  load_data = {{(DATA_W-16){1'b0}}, mctl_rdata[15:0]};
            default: load_data = mctl_rdata;
        endcase
    end

    assign done_now = (state == BUSY) && mctl_done;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_mem) state_next = BUSY;
            BUSY:    if (mctl_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                state      <= IDLE;
                mctl_req   <= 1'b0;
                mctl_we    <= 1'b0;
                mctl_addr  <= '0;
                mctl_wdata <= '0;
                mctl_len   <= 2'd0;
            end else begin
                state <= state_next;
                if (state == IDLE && is_mem) begin
                    mctl_req   <= 1'b1;
                    mctl_we    <= is_store;
                    mctl_addr  <= in_mem_addr;
                    mctl_wdata <= in_w_data;
                    mctl_len   <= op_len;
                end else if (done_now) begin
                    mctl_req <= 1'b0;
                end
            end
        end
    end

    // Write-back is only meaningful in the done cycle of a load; stores never write.
    always_comb begin
        stall_req = 1'b0;
        wb_w_addr = in_w_addr;
        wb_w_req  = in_w_req;
        wb_w_data = in_w_data;
        if (rst) begin
            wb_w_addr = '0;
            wb_w_req  = 1'b0;
            wb_w_data = '0;
        end else if (is_mem) begin
            stall_req = !done_now;
            if (is_store || !done_now) begin
                wb_w_req  = 1'b0;
                wb_w_data = '0;
            end else begin
                wb_w_data = load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected controller requests
// and write-backs; negedge monitors pop and compare as the DUT presents them.

module tb_mem_stage;

    localparam logic [4:0] EX_NOP = 5'h00;
    localparam logic [4:0] EX_ADD = 5'h01;
    localparam logic [4:0] EX_LB  = 5'h10;
    localparam logic [4:0] EX_LH  = 5'h11;
    localparam logic [4:0] EX_LW  = 5'h12;
    localparam logic [4:0] EX_LBU = 5'h13;
    localparam logic [4:0] EX_LHU = 5'h14;
    localparam logic [4:0] EX_SB  = 5'h15;
    localparam logic [4:0] EX_SH  = 5'h16;
    localparam logic [4:0] EX_SW  = 5'h17;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [4:0]  in_w_addr;
    logic        in_w_req;
    logic [31:0] in_w_data, in_mem_addr;
    logic [4:0]  in_aluop;
    logic        mctl_req, mctl_we;
    logic [31:0] mctl_addr, mctl_wdata;
    logic [1:0]  mctl_len;
    logic        mctl_done;
    logic [31:0] mctl_rdata;
    logic [4:0]  wb_w_addr;
    logic        wb_w_req;
    logic [31:0] wb_w_data;
    logic        stall_req;

    int tests = 0;
    int fails = 0;

    logic [66:0] req_q[$];
    logic [36:0] wb_q[$];
    logic        prev_req = 1'b0;

    mem_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_w_addr(in_w_addr), .in_w_req(in_w_req), .in_w_data(in_w_data),
        .in_mem_addr(in_mem_addr), .in_aluop(in_aluop),
        .mctl_req(mctl_req), .mctl_we(mctl_we), .mctl_addr(mctl_addr),
        .mctl_wdata(mctl_wdata), .mctl_len(mctl_len),
        .mctl_done(mctl_done), .mctl_rdata(mctl_rdata),
        .wb_w_addr(wb_w_addr), .wb_w_req(wb_w_req), .wb_w_data(wb_w_data),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request monitor: one pop per rising edge of mctl_req.
    always @(negedge clk) begin
        if (mctl_req && !prev_req) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", {mctl_we, mctl_len, mctl_addr, mctl_wdata}, 67'h0);
                if (!(mctl_we == 1'b0 && mctl_len == 2'd0 && mctl_addr == 32'h0 && mctl_wdata == 32'h0)) ;
                else begin
                    fails++;
                    $display("FAIL req_unexpected: request seen with nothing expected at %0t", $time);
                end
            end else begin
                check("req_fields", {mctl_we, mctl_len, mctl_addr, mctl_wdata}, req_q.pop_front());
            end
        end
        prev_req <= mctl_req;
    end

    // Write-back monitor: every cycle with wb_w_req high is one result.
    always @(negedge clk) begin
        if (wb_w_req) begin
            if (wb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got addr %0d data 0x%0h, expected none at %0t",
                         wb_w_addr, wb_w_data, $time);
            end else begin
                check("wb_result", {30'h0, wb_w_addr, wb_w_data}, {30'h0, wb_q.pop_front()});
            end
        end
    end

    task automatic alu_op(input logic [4:0] op, input logic [4:0] wa, input logic wr,
                          input logic [31:0] wd);
        in_aluop = op; in_w_addr = wa; in_w_req = wr; in_w_data = wd;
        if (wr) wb_q.push_back({wa, wd});
        #1;
        check("alu_wb_addr", wb_w_addr, wa);
        check("alu_wb_data", wb_w_data, wd);
        check("alu_wb_req", wb_w_req, wr);
        check("alu_stall", stall_req, 0);
        @(posedge clk); #1;
        check("alu_no_req", mctl_req, 0);
        in_aluop = EX_NOP; in_w_req = 1'b0;
    endtask

    // Called just after a posedge; returns just after the done-cycle edge.
    task automatic mem_op(input logic [4:0] op, input logic [4:0] wa, input logic wr,
                          input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] rd,
                          input int lat, input int freeze, input logic [1:0] len,
                          input logic [31:0] exp);
        logic we;
        we = (op == EX_SB || op == EX_SH || op == EX_SW);
        req_q.push_back({we, len, ma, wd});
        if (!we && wr) wb_q.push_back({wa, exp});
        in_aluop = op; in_w_addr = wa; in_w_req = wr; in_w_data = wd; in_mem_addr = ma;
        #1;
        check("issue_stall", stall_req, 1);
        check("issue_idle_req", mctl_req, 0);
        @(posedge clk); #1;
        check("busy_req", mctl_req, 1);
        check("busy_stall", stall_req, 1);
        if (freeze > 0) begin
            rdy = 1'b0;
            repeat (freeze) begin
                @(posedge clk); #1;
                check("freeze_req", mctl_req, 1);
                check("freeze_fields", {mctl_we, mctl_len, mctl_addr, mctl_wdata}, {we, len, ma, wd});
            end
            rdy = 1'b1;
        end
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            check("held_fields", {mctl_req, mctl_we, mctl_len, mctl_addr, mctl_wdata},
                  {1'b1, we, len, ma, wd});
            check("held_stall", stall_req, 1);
        end
        mctl_done = 1'b1; mctl_rdata = rd;
        #1;
        check("done_stall", stall_req, 0);
        if (we) begin
            check("store_wb_req", wb_w_req, 0);
            check("store_wb_data", wb_w_data, 0);
        end
        @(posedge clk); #1;
        mctl_done = 1'b0;
        in_aluop = EX_NOP; in_w_req = 1'b0;
        check("done_drops_req", mctl_req, 0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; mctl_done = 1'b0; mctl_rdata = 32'h0;
        in_aluop = EX_LW; in_w_addr = 5'd9; in_w_req = 1'b1;
        in_w_data = 32'h5555_AAAA; in_mem_addr = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mctl", {mctl_req, mctl_we, mctl_len, mctl_addr, mctl_wdata}, 67'h0);
        check("rst_stall", stall_req, 0);
        check("rst_wb", {wb_w_req, wb_w_addr, wb_w_data}, 38'h0);
        in_aluop = EX_NOP; in_w_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through
        alu_op(EX_ADD, 5'd5, 1'b1, 32'h0000_1234);
        alu_op(EX_ADD, 5'd7, 1'b0, 32'h0BAD_F00D);

        // Loads with sign/zero extension
        mem_op(EX_LB,  5'd3, 1'b1, 32'h0, 32'h100, 32'h0000_00F0, 3, 0, 2'd0, 32'hFFFF_FFF0);
        @(posedge clk); #1;
        mem_op(EX_LHU, 5'd4, 1'b1, 32'h0, 32'h104, 32'h0000_8001, 1, 0, 2'd1, 32'h0000_8001);
        @(posedge clk); #1;
        mem_op(EX_LH,  5'd6, 1'b1, 32'h0, 32'h108, 32'h0000_8001, 2, 0, 2'd1, 32'hFFFF_8001);
        @(posedge clk); #1;
        mem_op(EX_LW,  5'd8, 1'b1, 32'h0, 32'h10C, 32'hDEAD_BEEF, 1, 0, 2'd3, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Store held through BUSY
        mem_op(EX_SW, 5'd0, 1'b0, 32'hCAFE_BABE, 32'h2000, 32'h0, 3, 0, 2'd3, 32'h0);

        // Back-to-back store then load: the task boundary is the single IDLE cycle
        mem_op(EX_SB,  5'd0,  1'b0, 32'h1234_56A5, 32'h31, 32'h0, 1, 0, 2'd0, 32'h0);
        mem_op(EX_LBU, 5'd12, 1'b1, 32'h0, 32'h33, 32'hABCD_EF80, 2, 0, 2'd0, 32'h0000_0080);
        @(posedge clk); #1;

        // rdy=0 freeze mid-BUSY
        mem_op(EX_SH, 5'd0, 1'b0, 32'h0000_BEEF, 32'h402, 32'h0, 2, 4, 2'd1, 32'h0);
        @(posedge clk); #1;

        // done while IDLE is ignored
        mctl_done = 1'b1; mctl_rdata = 32'h1111_1111;
        #1;
        check("idle_done_stall", stall_req, 0);
        @(posedge clk); #1;
        mctl_done = 1'b0;
        check("idle_done_req", mctl_req, 0);

        // Reset while BUSY aborts the access; a late done is ignored
        req_q.push_back({1'b0, 2'd3, 32'h300, 32'h0});
        in_aluop = EX_LW; in_w_addr = 5'd10; in_w_req = 1'b1; in_w_data = 32'h0; in_mem_addr = 32'h300;
        @(posedge clk); #1;
        check("abort_busy_req", mctl_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_rst_stall", stall_req, 0);
        check("abort_rst_wb", {wb_w_req, wb_w_data}, 33'h0);
        @(posedge clk); #1;
        rst = 1'b0; in_aluop = EX_NOP; in_w_req = 1'b0;
        check("abort_req_dropped", mctl_req, 0);
        mctl_done = 1'b1; mctl_rdata = 32'h7777_7777;
        #1;
        check("late_done_stall", stall_req, 0);
        check("late_done_wb_req", wb_w_req, 0);
        @(posedge clk); #1;
        mctl_done = 1'b0;
        check("late_done_req", mctl_req, 0);

        // Same op after the abort issues normally
        mem_op(EX_LW, 5'd11, 1'b1, 32'h0, 32'h304, 32'h0102_0304, 1, 0, 2'd3, 32'h0102_0304);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("req_q_drained", req_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
